multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the next processor phase.
- Decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback.
- Generates every datapath control strobe, including the 2-bit alu_op consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = use funct[1:0].
- Talks to a shared instruction/data memory via a req/ready handshake.

Parameters:
- OPW, 4, opcode width.
- TRAP_STICKY, 1, 1 = illegal opcode parks the FSM in TRAP until reset; 0 = return to FETCH after one TRAP cycle.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  synchronous reset, active-high
- opcode  input  OPW  instruction register opcode field, valid from DECODE onward
- zero  input  1  ALU zero flag, used only in BRANCH
- mem_ready  input  1  memory completes the current read/write this cycle
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- iord  output  1  address select: 0 = PC, 1 = ALUOut
- ir_write  output  1  load instruction register
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by zero
- pc_source  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = reg B, 01 = constant increment, 10 = sign-ext imm, 11 = sign-ext imm shifted
- alu_op  output  2  to ALU control decoder
- reg_write  output  1  register file write enable
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALUOut, 1 = memory data register
- illegal_op  output  1  high while in TRAP
- instr_done  output  1  one-cycle pulse on the last cycle of each retired instruction
- state_o  output  4  current state code, for debug/verification

Behaviour:
- Reset (rst=1 at clk edge):
  - State becomes FETCH.
  - While rst is high, all outputs are forced to 0 and state_o reads FETCH.
- Outputs are Moore-decoded from the registered state, except the handshake-gated strobes noted below.
- Unlisted outputs are 0 in each state.
- Opcodes: 0000 R-type, 0001 addi, 0010 lw, 0011 sw, 0100 beq, 0101 j. All others are illegal.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_write = pc_write = mem_ready.
  - Holds while mem_ready=0; on mem_ready goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state: R-type -> EXEC_R; addi -> EXEC_I; lw/sw -> MEM_ADDR; beq -> BRANCH; j -> JUMP; illegal -> TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00; -> WB_I.
- WB_I: reg_write=1, reg_dst=0, instr_done=1; -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, iord=1; holds until mem_ready, then -> WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; -> FETCH.
- MEM_WR:
  - Drives mem_write=1, iord=1.
  - instr_done = mem_ready.
  - Holds until mem_ready, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1; -> FETCH.
  - The zero input is not used by the FSM itself; the datapath ANDs it with pc_write_cond.
- JUMP: pc_write=1, pc_source=10, instr_done=1; -> FETCH.
- TRAP: illegal_op=1; stays in TRAP if TRAP_STICKY=1, otherwise -> FETCH next cycle.
- Latency with zero wait states (cycles, FETCH inclusive): R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.
- mem_read and mem_write are never both high.
- Request strobes stay asserted and stable while mem_ready=0.
- rst mid-instruction, including during a memory wait: next state is FETCH and no write strobe is asserted in the reset cycle.
- Opcode changes outside DECODE and MEM_ADDR are ignored.
- mem_ready in states not waiting on memory is ignored.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - Opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - State encoding constants; the 4-bit state_o codes are fixed there.
  - ALU op constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - alu_src_b and pc_source encodings.
- One sub-module is natural: mc_ctrl_outdec, a purely combinational state-to-output decoder. Next-state logic and the state register remain in the top.

Test Plan:
- rst=1 for 2 cycles with mem_ready=1 -> all outputs 0; after release, state_o=FETCH and mem_read=1; first edge with mem_ready=1 pulses ir_write=1 and pc_write=1.
- opcode=0000, mem_ready always 1 -> states FETCH, DECODE, EXEC_R (alu_op=10), WB_R (reg_write=1, reg_dst=1); instr_done after 4 cycles.
- opcode=0010 with mem_ready low 3 cycles in MEM_RD -> mem_read=1, iord=1 held stable for 4 cycles; WB_MEM has mem_to_reg=1; total 8 cycles.
- opcode=0100 -> BRANCH cycle shows alu_op=01, pc_write_cond=1, pc_source=01; total 3 cycles. opcode=0101 -> JUMP shows pc_write=1, pc_source=10.
- opcode=1111 with TRAP_STICKY=1 -> illegal_op=1 indefinitely, no mem_read; then rst=1 for 1 cycle -> FETCH, illegal_op=0.
- opcode=0011 with rst asserted during MEM_WR while mem_ready=0 -> mem_write=0 in the reset cycle, next state FETCH, no instr_done.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control FSM: opcodes, state codes,
// ALU op / mux select encodings and the bundled control-strobe record.
package mc_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ASB_REG    = 2'b00;
    localparam logic [1:0] ASB_INC    = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-strobe decoder; only the memory-handshake strobes
// look at mem_ready, everything else is a pure function of the state.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ASB_INC;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ASB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ASB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCS_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control: state register and opcode-driven sequencing,
// with strobes decoded by mc_ctrl_outdec and forced low while rst is high.
module multicycle_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_read,
    output logic           mem_write,
    output logic           iord,
    output logic           ir_write,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic [1:0]     pc_source,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           illegal_op,
    output logic           instr_done,
    output logic [3:0]     state_o
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    ctrl_t  ctrl_g;

    // The branch decision is made in the datapath (zero AND pc_write_cond).
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if      (opcode == OPW'(OP_RTYPE)) state_next = S_EXEC_R;
                else if (opcode == OPW'(OP_ADDI))  state_next = S_EXEC_I;
                else if (opcode == OPW'(OP_LW))    state_next = S_MEM_ADDR;
                else if (opcode == OPW'(OP_SW))    state_next = S_MEM_ADDR;
                else if (opcode == OPW'(OP_BEQ))   state_next = S_BRANCH;
                else if (opcode == OPW'(OP_J))     state_next = S_JUMP;
                else                               state_next = S_TRAP;
            end
            S_EXEC_R:   state_next = S_WB_R;
            S_WB_R:     state_next = S_FETCH;
            S_EXEC_I:   state_next = S_WB_I;
            S_WB_I:     state_next = S_FETCH;
            S_MEM_ADDR: state_next = (opcode == OPW'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
            S_WB_MEM:   state_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_TRAP:     state_next = TRAP_STICKY ? S_TRAP : S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign ctrl_g  = rst ? '0 : ctrl;
    assign state_o = rst ? S_FETCH : state;

    assign mem_read      = ctrl_g.mem_read;
    assign mem_write     = ctrl_g.mem_write;
    assign iord          = ctrl_g.iord;
    assign ir_write      = ctrl_g.ir_write;
    assign pc_write      = ctrl_g.pc_write;
    assign pc_write_cond = ctrl_g.pc_write_cond;
    assign pc_source     = ctrl_g.pc_source;
    assign alu_src_a     = ctrl_g.alu_src_a;
    assign alu_src_b     = ctrl_g.alu_src_b;
    assign alu_op        = ctrl_g.alu_op;
    assign reg_write     = ctrl_g.reg_write;
    assign reg_dst       = ctrl_g.reg_dst;
    assign mem_to_reg    = ctrl_g.mem_to_reg;
    assign illegal_op    = ctrl_g.illegal_op;
    assign instr_done    = ctrl_g.instr_done;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: per-instruction expected cycle sequences
// built from opcode and random wait counts, plus end-to-end latency checks.
module tb_multicycle_main_control;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op, instr_done;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       mr, mw, iord, irw, pcw, pcwc;
        logic [1:0] pcs;
        logic       asa;
        logic [1:0] asb, aop;
        logic       rw, rd, m2r, ill, done;
    } exp_t;

    multicycle_main_control #(.OPW(4), .TRAP_STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_op(illegal_op), .instr_done(instr_done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(state_t s);
        exp_t e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic exp_t ex_fetch(logic rdy);
        exp_t e = ex(S_FETCH);
        e.mr = 1'b1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction

    task automatic check(string tag, exp_t e);
        exp_t o;
        o.st = state_o; o.mr = mem_read; o.mw = mem_write; o.iord = iord;
        o.irw = ir_write; o.pcw = pc_write; o.pcwc = pc_write_cond; o.pcs = pc_source;
        o.asa = alu_src_a; o.asb = alu_src_b; o.aop = alu_op; o.rw = reg_write;
        o.rd = reg_dst; o.m2r = mem_to_reg; o.ill = illegal_op; o.done = instr_done;
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(logic r, logic rdy, logic [3:0] op, exp_t e, string tag);
        rst = r; mem_ready = rdy; opcode = op; zero = 1'($urandom);
        #2;
        check(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(logic [3:0] op, int fw, int mwt);
        exp_t e;
        for (int i = 0; i < fw; i++) cyc(1'b0, 1'b0, 4'($urandom), ex_fetch(1'b0), "fetch_wait");
        cyc(1'b0, 1'b1, 4'($urandom), ex_fetch(1'b1), "fetch");
        e = ex(S_DECODE); e.asb = 2'b11;
        cyc(1'b0, 1'($urandom), op, e, "decode");
        case (op)
            OP_RTYPE: begin
                e = ex(S_EXEC_R); e.asa = 1'b1; e.aop = 2'b10;
                cyc(1'b0, 1'($urandom), 4'($urandom), e, "exec_r");
                e = ex(S_WB_R); e.rw = 1'b1; e.rd = 1'b1; e.done = 1'b1;
                cyc(1'b0, 1'($urandom), 4'($urandom), e, "wb_r");
            end
            OP_ADDI: begin
                e = ex(S_EXEC_I); e.asa = 1'b1; e.asb = 2'b10;
                cyc(1'b0, 1'($urandom), 4'($urandom), e, "exec_i");
                e = ex(S_WB_I); e.rw = 1'b1; e.done = 1'b1;
                cyc(1'b0, 1'($urandom), 4'($urandom), e, "wb_i");
            end
            OP_LW, OP_SW: begin
                e = ex(S_MEM_ADDR); e.asa = 1'b1; e.asb = 2'b10;
                cyc(1'b0, 1'($urandom), op, e, "mem_addr");
                if (op == OP_LW) begin
                    e = ex(S_MEM_RD); e.mr = 1'b1; e.iord = 1'b1;
                    for (int i = 0; i < mwt; i++) cyc(1'b0, 1'b0, 4'($urandom), e, "mem_rd_wait");
                    cyc(1'b0, 1'b1, 4'($urandom), e, "mem_rd");
                    e = ex(S_WB_MEM); e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
                    cyc(1'b0, 1'($urandom), 4'($urandom), e, "wb_mem");
                end else begin
                    e = ex(S_MEM_WR); e.mw = 1'b1; e.iord = 1'b1;
                    for (int i = 0; i < mwt; i++) cyc(1'b0, 1'b0, 4'($urandom), e, "mem_wr_wait");
                    e.done = 1'b1;
                    cyc(1'b0, 1'b1, 4'($urandom), e, "mem_wr");
                end
            end
            OP_BEQ: begin
                e = ex(S_BRANCH); e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1;
                e.pcs = 2'b01; e.done = 1'b1;
                cyc(1'b0, 1'($urandom), 4'($urandom), e, "branch");
            end
            default: begin
                e = ex(S_JUMP); e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1;
                cyc(1'b0, 1'($urandom), 4'($urandom), e, "jump");
            end
        endcase
    endtask

    // Count cycles from FETCH until the DUT itself reports instr_done.
    task automatic measure(logic [3:0] op, int expl);
        int  n    = 0;
        bit  seen = 1'b0;
        rst = 1'b0; mem_ready = 1'b1; opcode = op;
        while (!seen && n < 20) begin
            #2;
            n++;
            if (instr_done === 1'b1) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        total++;
        assert (seen && n == expl) else begin
            bad++;
            $error("FAIL latency op=%0d observed=%0d expected=%0d", op, n, expl);
        end
    endtask

    task automatic run_trap(logic [3:0] op);
        exp_t e;
        cyc(1'b0, 1'b1, 4'($urandom), ex_fetch(1'b1), "fetch");
        e = ex(S_DECODE); e.asb = 2'b11;
        cyc(1'b0, 1'($urandom), op, e, "decode_ill");
        e = ex(S_TRAP); e.ill = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'($urandom), 4'($urandom), e, "trap_sticky");
        cyc(1'b1, 1'($urandom), 4'($urandom), '0, "trap_rst");
        cyc(1'b0, 1'b0, 4'($urandom), ex_fetch(1'b0), "after_trap");
    endtask

    logic [3:0] legal [6];
    int         lat   [6];

    initial begin
        exp_t e;
        legal = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        lat   = '{4, 4, 5, 4, 3, 3};
        rst = 1'b1; mem_ready = 1'b1; opcode = '0; zero = 1'b0;
        @(posedge clk);
        #1;

        cyc(1'b1, 1'b1, 4'h0, '0, "reset0");
        cyc(1'b1, 1'b1, 4'h3, '0, "reset1");
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_BEQ, 1, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_ADDI, 2, 0);
        run_instr(OP_SW, 0, 2);

        for (int i = 0; i < 6; i++) measure(legal[i], lat[i]);
        measure(OP_LW, 5);

        for (int i = 0; i < 40; i++)
            run_instr(legal[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3));

        // Reset while a store is stalled on memory.
        cyc(1'b0, 1'b1, 4'h0, ex_fetch(1'b1), "sw_fetch");
        e = ex(S_DECODE); e.asb = 2'b11;
        cyc(1'b0, 1'b0, OP_SW, e, "sw_decode");
        e = ex(S_MEM_ADDR); e.asa = 1'b1; e.asb = 2'b10;
        cyc(1'b0, 1'b0, OP_SW, e, "sw_addr");
        e = ex(S_MEM_WR); e.mw = 1'b1; e.iord = 1'b1;
        cyc(1'b0, 1'b0, 4'h0, e, "sw_wait");
        cyc(1'b1, 1'b0, 4'h0, '0, "sw_rst");
        cyc(1'b0, 1'b0, 4'h0, ex_fetch(1'b0), "sw_after_rst");
        run_instr(OP_ADDI, 0, 0);

        run_trap(4'b1111);
        run_trap(4'($urandom_range(6, 14)));
        run_instr(OP_RTYPE, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
